// File: rtl/rst_clk_seq_pkg.sv
// Shared types and constants for the reset/clock-enable sequencer.
package rst_clk_seq_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      DEBOUNCE  = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } seq_state_e;

   localparam logic [1:0] CAUSE_POR  = 2'b00;
   localparam logic [1:0] CAUSE_SW   = 2'b01;
   localparam logic [1:0] CAUSE_LOCK = 2'b10;

   // Counter must span both the debounce window and the full stagger window.
   function automatic int unsigned cnt_width(input int unsigned deb,
                                             input int unsigned n_ch,
                                             input int unsigned stagger);
      int unsigned span;
      span = (n_ch - 1) * stagger + 1;
      if (deb > span) span = deb;
      return (span <= 1) ? 32'd1 : 32'($clog2(span));
   endfunction

endpackage

// File: rtl/rst_clk_sequencer_sync_bit.sv
// Multi-flop synchroniser with asynchronous active-low clear.
module sync_bit #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chain <= '0;
      else        chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/rst_clk_sequencer.sv
// Sequences NUM_CH reset domains off a debounced PLL lock, with staggered
// release, registered clock enables and a sticky reset-cause record.
module rst_clk_sequencer
   import rst_clk_seq_pkg::*;
#(
   parameter int unsigned NUM_CH          = 4,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1024,
   parameter int unsigned STAGGER_CYCLES  = 8
) (
   input  logic              clk,
   input  logic              reset_button_n,
   input  logic              pll_locked,
   input  logic              sw_reset_req,
   input  logic [NUM_CH-1:0] ch_clk_en_req,
   output logic [NUM_CH-1:0] rst_n_out,
   output logic [NUM_CH-1:0] clk_en,
   output logic              sys_ready,
   output logic [1:0]        reset_cause
);

   localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES, NUM_CH, STAGGER_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic rst_sync_n;
   logic lock_s;

   seq_state_e        state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d, cnt_inc;
   logic [NUM_CH-1:0] rst_d, clk_en_d, stagger_hit;
   logic              ready_d;
   logic [1:0]        cause_d;

   // Button assertion clears everything at once; release waits out the chain.
   sync_bit #(.STAGES(SYNC_STAGES)) u_rst_sync (
      .clk   (clk),
      .rst_n (reset_button_n),
      .d     (1'b1),
      .q     (rst_sync_n)
   );

   sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .clk   (clk),
      .rst_n (reset_button_n),
      .d     (pll_locked),
      .q     (lock_s)
   );

   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

   // Channel g is due when the stagger counter reaches g*STAGGER_CYCLES.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_hit
      assign stagger_hit[g] = (cnt_inc == CNT_W'(g * STAGGER_CYCLES));
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      rst_d   = rst_n_out;
      ready_d = sys_ready;
      cause_d = reset_cause;

      unique case (state)
         WAIT_LOCK: begin
            rst_d   = '0;
            ready_d = 1'b0;
            cnt_d   = '0;
            if (lock_s) state_d = DEBOUNCE;
         end
         DEBOUNCE: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
               cause_d = CAUSE_LOCK;
            end else if (cnt == DEB_LAST) begin
               state_d  = RELEASE;
               cnt_d    = '0;
               rst_d[0] = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         RELEASE: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
               rst_d   = '0;
               ready_d = 1'b0;
               cause_d = CAUSE_LOCK;
            end else begin
               cnt_d = cnt_inc;
               rst_d = rst_n_out | stagger_hit;
               if (rst_n_out[NUM_CH-1]) begin
                  state_d = RUN;
                  ready_d = 1'b1;
               end
            end
         end
         RUN: begin
            // Lock loss outranks a coincident software request.
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
               rst_d   = '0;
               ready_d = 1'b0;
               cause_d = CAUSE_LOCK;
            end else if (sw_reset_req) begin
               state_d = DEBOUNCE;
               cnt_d   = '0;
               rst_d   = '0;
               ready_d = 1'b0;
               cause_d = CAUSE_SW;
            end
         end
         default: state_d = WAIT_LOCK;
      endcase

      // Enable follows an already-released channel and drops with its reset.
      clk_en_d = rst_d & rst_n_out & ch_clk_en_req;
   end

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state       <= WAIT_LOCK;
         cnt         <= '0;
         rst_n_out   <= '0;
         clk_en      <= '0;
         sys_ready   <= 1'b0;
         reset_cause <= CAUSE_POR;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         rst_n_out   <= rst_d;
         clk_en      <= clk_en_d;
         sys_ready   <= ready_d;
         reset_cause <= cause_d;
      end
   end

endmodule

// File: tb/tb_rst_clk_sequencer.sv
// Scoreboard bench: a time-based reference model predicts every cycle's outputs.
module tb_rst_clk_sequencer;
   import rst_clk_seq_pkg::*;

   localparam int N        = 4;
   localparam int SS       = 2;
   localparam int DEB      = 16;
   localparam int STG      = 4;
   localparam int REL_SPAN = (N - 1) * STG;

   typedef struct packed {
      logic [N-1:0] rst;
      logic [N-1:0] en;
      logic         rdy;
      logic [1:0]   cause;
   } obs_t;

   logic         clk;
   logic         reset_button_n;
   logic         pll_locked;
   logic         sw_reset_req;
   logic [N-1:0] ch_clk_en_req;
   logic [N-1:0] rst_n_out;
   logic [N-1:0] clk_en;
   logic         sys_ready;
   logic [1:0]   reset_cause;

   int checks   = 0;
   int failures = 0;

   rst_clk_sequencer #(
      .NUM_CH          (N),
      .SYNC_STAGES     (SS),
      .DEBOUNCE_CYCLES (DEB),
      .STAGGER_CYCLES  (STG)
   ) dut (
      .clk            (clk),
      .reset_button_n (reset_button_n),
      .pll_locked     (pll_locked),
      .sw_reset_req   (sw_reset_req),
      .ch_clk_en_req  (ch_clk_en_req),
      .rst_n_out      (rst_n_out),
      .clk_en         (clk_en),
      .sys_ready      (sys_ready),
      .reset_cause    (reset_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // phase: 0 waiting for lock, 1 debouncing, 2 released (t = edges since release start)
   obs_t         exp_q[$];
   int           m_phase = 0;
   int           m_dcnt  = 0;
   int           m_t     = 0;
   int           m_rsync = 0;
   logic         m_ls1   = 1'b0;
   logic         m_ls2   = 1'b0;
   logic [1:0]   m_cause = CAUSE_POR;
   logic [N-1:0] m_rst   = '0;
   logic [N-1:0] m_en    = '0;
   logic [N-1:0] m_rst_new;
   logic         m_rdy   = 1'b0;

   function automatic logic [N-1:0] rel_mask(input int t);
      logic [N-1:0] mask;
      mask = '0;
      for (int i = N - 1; i >= 0; i--) mask = {mask[N-2:0], 1'(t >= i * STG)};
      return mask;
   endfunction

   always @(posedge clk or negedge reset_button_n) begin
      if (!reset_button_n) begin
         m_phase = 0; m_dcnt = 0; m_t = 0; m_rsync = 0;
         m_ls1 = 1'b0; m_ls2 = 1'b0;
         m_cause = CAUSE_POR; m_rst = '0; m_en = '0; m_rdy = 1'b0;
         exp_q.delete();
         exp_q.push_back('0);
      end else begin
         if (m_rsync >= SS) begin
            case (m_phase)
               0: if (m_ls2) begin m_phase = 1; m_dcnt = 0; end
               1: begin
                  if (!m_ls2) begin m_phase = 0; m_cause = CAUSE_LOCK; end
                  else if (m_dcnt == DEB - 1) begin m_phase = 2; m_t = 0; end
                  else m_dcnt++;
               end
               default: begin
                  if (!m_ls2) begin m_phase = 0; m_cause = CAUSE_LOCK; end
                  else if (m_t > REL_SPAN && sw_reset_req) begin
                     m_phase = 1; m_dcnt = 0; m_cause = CAUSE_SW;
                  end else if (m_t < 1000) m_t++;
               end
            endcase
         end else begin
            m_rsync++;
         end
         m_ls2 = m_ls1;
         m_ls1 = pll_locked;
         m_rst_new = (m_phase == 2) ? rel_mask(m_t) : '0;
         m_en      = m_rst_new & m_rst & ch_clk_en_req;
         m_rst     = m_rst_new;
         m_rdy     = (m_phase == 2) && (m_t > REL_SPAN);
         exp_q.push_back({m_rst, m_en, m_rdy, m_cause});
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      obs_t e, g;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = {rst_n_out, clk_en, sys_ready, reset_cause};
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL scoreboard @%0t: got rst=%b en=%b rdy=%b cause=%b, expected rst=%b en=%b rdy=%b cause=%b",
                     $time, g.rst, g.en, g.rdy, g.cause, e.rst, e.en, e.rdy, e.cause);
         end
      end
   end

   // ---------------- directed helpers ----------------
   int first_rise[$];
   int rdy_rise;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Records the edge index (k0 = next edge) at which each output first rises.
   task automatic measure(input int k0, input int n);
      first_rise = {};
      for (int i = 0; i < N; i++) first_rise.push_back(-1);
      rdy_rise = -1;
      for (int k = k0; k < k0 + n; k++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            logic [N-1:0] sh;
            sh = rst_n_out >> i;
            if (sh[0] && first_rise[i] < 0) first_rise[i] = k;
         end
         if (sys_ready && rdy_rise < 0) rdy_rise = k;
         #1;
      end
   endtask

   task automatic check_release(input string name, input int base);
      for (int i = 0; i < N; i++)
         check($sformatf("%s_rise%0d", name, i), first_rise[i], base + i * STG);
      check($sformatf("%s_ready", name), rdy_rise, base + REL_SPAN + 1);
   endtask

   task automatic check_async_clear(input string name);
      #1;
      check({name, "_rst"},   int'(rst_n_out),   0);
      check({name, "_en"},    int'(clk_en),      0);
      check({name, "_rdy"},   int'(sys_ready),   0);
      check({name, "_cause"}, int'(reset_cause), int'(CAUSE_POR));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      reset_button_n = 1'b0;
      pll_locked     = 1'b0;
      sw_reset_req   = 1'b0;
      ch_clk_en_req  = '0;
      step(3);
      check_async_clear("por");
      reset_button_n = 1'b1;
      step(4);

      // Power-up: T0 is the next edge after lock rises.
      pll_locked = 1'b1;
      measure(0, 34);
      check_release("powerup", SS + DEB);
      check("powerup_cause", int'(reset_cause), int'(CAUSE_POR));

      // Clock enable request, then software re-sequence.
      ch_clk_en_req = 4'b1010;
      step(1);
      check("req_clk_en", int'(clk_en), 4'b1010);
      sw_reset_req = 1'b1;
      step(1);
      sw_reset_req = 1'b0;
      check("sw_rst", int'(rst_n_out), 0);
      check("sw_en", int'(clk_en), 0);
      check("sw_cause", int'(reset_cause), int'(CAUSE_SW));
      measure(1, 32);
      check_release("sw", DEB);

      // Lock loss in RUN: outputs drop on the third edge after the fall.
      pll_locked = 1'b0;
      step(2);
      check("lockloss_hold", int'(rst_n_out), 4'hF);
      step(1);
      check("lockloss_rst", int'(rst_n_out), 0);
      check("lockloss_rdy", int'(sys_ready), 0);
      check("lockloss_cause", int'(reset_cause), int'(CAUSE_LOCK));

      // Short lock glitch mid-debounce restarts the debounce.
      pll_locked = 1'b1;
      step(8);
      pll_locked = 1'b0;
      step(3);
      pll_locked = 1'b1;
      measure(0, 34);
      check_release("glitch", SS + DEB);

      // Lock loss during RELEASE after two channels are out.
      pll_locked = 1'b0;
      step(6);
      pll_locked = 1'b1;
      step(SS + DEB + STG + 1);
      check("partial_rel", int'(rst_n_out), 4'b0011);
      pll_locked = 1'b0;
      step(3);
      check("partial_lost", int'(rst_n_out), 0);
      check("partial_cause", int'(reset_cause), int'(CAUSE_LOCK));

      // Coincident lock loss and software request in RUN.
      pll_locked = 1'b1;
      measure(0, 34);
      pll_locked = 1'b0;
      step(2);
      sw_reset_req = 1'b1;
      step(1);
      sw_reset_req = 1'b0;
      check("simul_cause", int'(reset_cause), int'(CAUSE_LOCK));
      check("simul_rst", int'(rst_n_out), 0);

      // Button pulse mid-RELEASE clears outputs without a clock edge.
      pll_locked    = 1'b1;
      ch_clk_en_req = 4'hF;
      step(SS + DEB + STG + 2);
      check("btn_pre_rst", int'(rst_n_out), 4'b0011);
      reset_button_n = 1'b0;
      check_async_clear("btn");
      #1;
      step(2);
      reset_button_n = 1'b1;
      step(3);

      // Randomised traffic checked by the scoreboard.
      for (int it = 0; it < 80; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: begin
               ch_clk_en_req = 4'($urandom);
               step($urandom_range(1, 10));
            end
            4, 9: begin
               ch_clk_en_req = 4'($urandom);
               sw_reset_req  = 1'b1;
               step(1);
               sw_reset_req  = 1'b0;
               step($urandom_range(1, 4));
            end
            5: begin
               pll_locked = 1'b0;
               step($urandom_range(1, 4));
               pll_locked = 1'b1;
            end
            6: step(40);
            7: begin
               reset_button_n = 1'b0;
               check_async_clear("rnd_btn");
               step($urandom_range(1, 3));
               reset_button_n = 1'b1;
            end
            default: begin
               pll_locked = 1'b0;
               step($urandom_range(5, 20));
               pll_locked = 1'b1;
            end
         endcase
      end
      step(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
